tick_scheduler: RTL

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Four independent programmable tick generators configured through a single command port.
// Defining TICK_SCHEDULER_TOGGLE_EN adds CLK_OUT, a per-channel square wave that flips on every tick.
module tick_scheduler #(
   parameter int DIV_W       = 24,
   parameter int DEFAULT_DIV = 50
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [1:0]       CMD_CH,
   input  logic [1:0]       CMD_OP,
   input  logic [DIV_W-1:0] CMD_DIV,
   output logic [3:0]       TICK,
   output logic [3:0]       ACTIVE
`ifdef TICK_SCHEDULER_TOGGLE_EN
   ,
   output logic [3:0]       CLK_OUT
`endif
);

   localparam logic [1:0]       OP_STOP     = 2'd0;
   localparam logic [1:0]       OP_PERIODIC = 2'd1;
   localparam logic [1:0]       OP_ONESHOT  = 2'd2;
   localparam logic [DIV_W-1:0] DEF_D       = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

   logic r_ready;
   logic w_accept;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_ready <= 1'b0;
      else          r_ready <= 1'b1;
   end

   assign CMD_READY = r_ready;
   assign w_accept  = CMD_VALID & r_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic [DIV_W-1:0] r_div;
         logic [DIV_W-1:0] r_pend_div;
         logic [DIV_W-1:0] r_cnt;
         logic             r_pend;
         logic             r_oneshot;
         logic             r_active;
         logic             r_tick;

         logic             w_sel;
         logic             w_start;
         logic             w_stop;
         logic             w_term;
         logic             w_ends;
         logic             w_tick_next;
         logic [DIV_W-1:0] w_div_eff;
         logic [DIV_W-1:0] w_pend_eff;
         logic [DIV_W-1:0] w_div_after;
         logic [DIV_W-1:0] w_cnt_next;

         assign w_sel      = w_accept && (CMD_CH == 2'(gi));
         assign w_start    = w_sel && ((CMD_OP == OP_PERIODIC) || (CMD_OP == OP_ONESHOT));
         assign w_stop     = w_sel && (CMD_OP == OP_STOP);
         assign w_div_eff  = (r_div == '0) ? ONE : r_div;
         assign w_pend_eff = (r_pend_div == '0) ? ONE : r_pend_div;
         // Counter runs 1..D; the cycle holding D is the tick cycle (terminal count).
         assign w_term      = r_active && (r_cnt >= w_div_eff);
         assign w_ends      = w_term && r_oneshot;
         assign w_div_after = (w_term && r_pend) ? w_pend_eff : w_div_eff;
         assign w_cnt_next  = w_term ? ONE : (r_cnt + ONE);

         always_comb begin
            w_tick_next = 1'b0;
            if (w_start)
               w_tick_next = (w_div_after == ONE);
            else if (!w_stop && r_active && !w_ends)
               w_tick_next = (w_cnt_next == w_div_after);
         end

         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               r_div      <= DEF_D;
               r_pend_div <= '0;
               r_pend     <= 1'b0;
               r_cnt      <= '0;
               r_oneshot  <= 1'b0;
               r_active   <= 1'b0;
               r_tick     <= 1'b0;
            end else begin
               r_tick <= w_tick_next;
               if (r_active)
                  r_cnt <= w_cnt_next;
               if (w_term && r_pend) begin
                  r_div  <= r_pend_div;
                  r_pend <= 1'b0;
               end
               if (w_ends) begin
                  r_active <= 1'b0;
                  r_cnt    <= '0;
               end
               // Commands are applied after the tick bookkeeping so they take priority.
               if (w_sel) begin
                  case (CMD_OP)
                     OP_STOP: begin
                        if (r_active) begin
                           r_active <= 1'b0;
                           r_cnt    <= '0;
                           if (r_pend) begin
                              r_div  <= r_pend_div;
                              r_pend <= 1'b0;
                           end
                        end
                     end
                     OP_PERIODIC, OP_ONESHOT: begin
                        r_active  <= 1'b1;
                        r_oneshot <= (CMD_OP == OP_ONESHOT);
                        r_cnt     <= ONE;
                     end
                     default: begin
                        if (r_active && !w_ends) begin
                           r_pend_div <= CMD_DIV;
                           r_pend     <= 1'b1;
                        end else begin
                           r_div <= CMD_DIV;
                        end
                     end
                  endcase
               end
            end
         end

         assign TICK[gi]   = r_tick;
         assign ACTIVE[gi] = r_active;

`ifdef TICK_SCHEDULER_TOGGLE_EN
         logic r_clk_out;

         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N)        r_clk_out <= 1'b0;
            else if (w_tick_next) r_clk_out <= ~r_clk_out;
         end

         assign CLK_OUT[gi] = r_clk_out;
`endif
      end
   endgenerate

endmodule
